// File: rtl/random_color.sv
// ---------------------------------------------------------------------------
// random_color
//   Pseudo-random 8-bit colour source for the VGA controller. It sits beside
//   the pixel pipeline. A 16-bit maximal-length Galois LFSR advances once per
//   update tick, and on that tick its low byte is registered onto the output
//   as an RGB332 pixel colour. The block is synchronous to the reference
//   clock; only the reset acts asynchronously.
//
// Parameters
//   SEED    LFSR reset value. A value of 0 is replaced by 16'h0001 so the
//           LFSR cannot lock up.
//   TAPS    Galois feedback mask. The default 16'hB400 gives
//           x^16+x^14+x^13+x^11+1.
//   PERIOD  Number of clocks per update tick (must be >= 1). A value of 1
//           produces a new colour on every clock.
//
// Ports
//   clk_referencia  in   1  reference clock, rising-edge active
//   reset           in   1  asynchronous reset, active low
//   data            out  8  colour: [7:5]=R, [4:2]=G, [1:0]=B
// ---------------------------------------------------------------------------
module random_color #(
    parameter logic [15:0] SEED   = 16'hACE1,
    parameter logic [15:0] TAPS   = 16'hB400,
    parameter int          PERIOD = 1
) (
    input  logic       clk_referencia,
    input  logic       reset,
    output logic [7:0] data
);

    localparam int          CNT_W    = $clog2(PERIOD) + 1;
    localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD - 1);

    logic [15:0]      lfsr_q, lfsr_d;
    logic [CNT_W-1:0] cnt_q,  cnt_d;
    logic [7:0]       data_q, data_d;
    logic             tick;

    // One Galois step: shift right, then fold the feedback mask back in
    // whenever a 1 is shifted out of bit 0.
    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {1'b0, s[15:1]} ^ (s[0] ? TAPS : 16'h0000);
    endfunction

    // With PERIOD==1, CNT_LAST is 0. The tick is then always high and the
    // counter stays at 0.
    always_comb begin
        tick   = (cnt_q == CNT_LAST);
        cnt_d  = tick ? '0 : cnt_q + 1'b1;
        lfsr_d = lfsr_q;
        data_d = data_q;
        if (tick) begin
            lfsr_d = lfsr_step(lfsr_q);
            data_d = lfsr_d[7:0];
        end
    end

    always_ff @(posedge clk_referencia or negedge reset) begin
        if (!reset) begin
            lfsr_q <= SEED_EFF;
            cnt_q  <= '0;
            data_q <= 8'h00;
        end else begin
            lfsr_q <= lfsr_d;
            cnt_q  <= cnt_d;
            data_q <= data_d;
        end
    end

    assign data = data_q;

endmodule

// File: tb/tb_random_color.sv
module tb_random_color;

    localparam logic [15:0] TAPS_C = 16'hB400;
    localparam int N = 4;

    logic       clk;
    logic       rst_n;
    logic [7:0] dat [N];

    int errors;
    int checks;

    // Reference model: one entry per DUT instance.
    int          m_period [N] = '{1, 2, 5, 1};
    logic [15:0] m_seed   [N] = '{16'hACE1, 16'hACE1, 16'hACE1, 16'h0000};
    logic [15:0] m_lfsr   [N];
    int          m_edges  [N];
    logic [7:0]  m_data   [N];

    random_color #(.SEED(16'hACE1), .TAPS(16'hB400), .PERIOD(1)) u_p1
        (.clk_referencia(clk), .reset(rst_n), .data(dat[0]));
    random_color #(.SEED(16'hACE1), .TAPS(16'hB400), .PERIOD(2)) u_p2
        (.clk_referencia(clk), .reset(rst_n), .data(dat[1]));
    random_color #(.SEED(16'hACE1), .TAPS(16'hB400), .PERIOD(5)) u_p5
        (.clk_referencia(clk), .reset(rst_n), .data(dat[2]));
    random_color #(.SEED(16'h0000), .TAPS(16'hB400), .PERIOD(1)) u_s0
        (.clk_referencia(clk), .reset(rst_n), .data(dat[3]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] ref_next(input logic [15:0] s);
        return (s / 2) ^ (((s % 2) == 1) ? TAPS_C : 16'h0000);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_lfsr[i]  = (m_seed[i] == 0) ? 16'h0001 : m_seed[i];
            m_edges[i] = 0;
            m_data[i]  = 8'h00;
        end
    endtask

    // Advance to just after the next rising edge and update the model.
    // A new colour appears on every PERIOD-th edge counted from reset release.
    task automatic tick_edge();
        @(posedge clk);
        #1;
        if (rst_n) begin
            for (int i = 0; i < N; i++) begin
                m_edges[i]++;
                if (m_edges[i] % m_period[i] == 0) begin
                    m_lfsr[i] = ref_next(m_lfsr[i]);
                    m_data[i] = m_lfsr[i][7:0];
                end
            end
        end
    endtask

    task automatic reset_and_release();
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        for (int e = 0; e < 5; e++) begin
            tick_edge();
            for (int i = 0; i < N; i++) begin
                checks++;
                if (dat[i] !== 8'h00) begin
                    errors++;
                    $display("FAIL reset_hold inst%0d edge%0d: got %h want 00", i, e, dat[i]);
                end
            end
        end
        checks++;
        if (u_s0.lfsr_q !== 16'h0001) begin
            errors++;
            $display("FAIL seed0_reset_lfsr: got %h want 0001", u_s0.lfsr_q);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick_edge();
        tick_edge();
        // Reset is applied while the clock is high, and the output must
        // clear without waiting for any clock edge.
        #1;
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if (clk !== 1'b1) begin
            errors++;
            $display("FAIL async_setup: clk got %b want 1", clk);
        end
        for (int i = 0; i < N; i++) begin
            checks++;
            if (dat[i] !== 8'h00) begin
                errors++;
                $display("FAIL reset_async inst%0d: got %h want 00", i, dat[i]);
            end
        end
    endtask

    task automatic test_period1_seq();
        logic [7:0] exp [4] = '{8'h70, 8'h38, 8'h9C, 8'h4E};
        reset_and_release();
        for (int e = 0; e < 4; e++) begin
            tick_edge();
            checks++;
            if (dat[0] !== exp[e]) begin
                errors++;
                $display("FAIL p1_seq edge%0d: got %h want %h", e + 1, dat[0], exp[e]);
            end
        end
    endtask

    task automatic test_period2_seq();
        logic [7:0] exp [4] = '{8'h00, 8'h70, 8'h70, 8'h38};
        reset_and_release();
        for (int e = 0; e < 4; e++) begin
            tick_edge();
            checks++;
            if (dat[1] !== exp[e]) begin
                errors++;
                $display("FAIL p2_seq edge%0d: got %h want %h", e + 1, dat[1], exp[e]);
            end
        end
    endtask

    task automatic test_reset_midrun();
        reset_and_release();
        for (int e = 0; e < 3; e++) tick_edge();
        #1;
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if (dat[0] !== 8'h00) begin
            errors++;
            $display("FAIL midrun_reset: got %h want 00", dat[0]);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick_edge();
        checks++;
        if (dat[0] !== 8'h70) begin
            errors++;
            $display("FAIL midrun_restart: got %h want 70", dat[0]);
        end
    endtask

    task automatic test_seed_zero();
        logic [7:0]  exp_d [2] = '{8'h00, 8'h00};
        logic [15:0] exp_l [2] = '{16'hB400, 16'h5A00};
        reset_and_release();
        for (int e = 0; e < 2; e++) begin
            tick_edge();
            checks++;
            if (dat[3] !== exp_d[e] || u_s0.lfsr_q !== exp_l[e]) begin
                errors++;
                $display("FAIL seed0 tick%0d: got data %h lfsr %h want data %h lfsr %h",
                         e + 1, dat[3], u_s0.lfsr_q, exp_d[e], exp_l[e]);
            end
        end
    endtask

    task automatic test_random();
        reset_and_release();
        for (int it = 0; it < 200; it++) begin
            int run_len;
            run_len = $urandom_range(1, 20);
            for (int e = 0; e < run_len; e++) begin
                tick_edge();
                for (int i = 0; i < N; i++) begin
                    checks++;
                    if (dat[i] !== m_data[i]) begin
                        errors++;
                        $display("FAIL random it%0d inst%0d: got %h want %h",
                                 it, i, dat[i], m_data[i]);
                    end
                end
            end
            if ($urandom_range(0, 7) == 0) begin
                int hold;
                hold = $urandom_range(0, 3);
                #1;
                rst_n = 1'b0;
                model_reset();
                for (int h = 0; h < hold; h++) tick_edge();
                @(negedge clk);
                for (int i = 0; i < N; i++) begin
                    checks++;
                    if (dat[i] !== 8'h00) begin
                        errors++;
                        $display("FAIL random_reset it%0d inst%0d: got %h want 00", it, i, dat[i]);
                    end
                end
                rst_n = 1'b1;
            end
        end
    endtask

    task automatic test_full_period();
        int zero_hits;
        int data_bad;
        zero_hits = 0;
        data_bad  = 0;
        reset_and_release();
        for (int e = 0; e < 65535; e++) begin
            tick_edge();
            if (u_p1.lfsr_q == 16'h0000) zero_hits++;
            if (dat[0] !== m_data[0]) begin
                if (data_bad == 0)
                    $display("FAIL full_seq edge%0d: got %h want %h", e + 1, dat[0], m_data[0]);
                data_bad++;
            end
        end
        checks++;
        if (data_bad != 0) begin
            errors++;
            $display("FAIL full_seq_count: got %0d bad edges want 0", data_bad);
        end
        checks++;
        if (zero_hits != 0) begin
            errors++;
            $display("FAIL lfsr_zero: got %0d zero states want 0", zero_hits);
        end
        checks++;
        if (u_p1.lfsr_q !== 16'hACE1) begin
            errors++;
            $display("FAIL wrap_lfsr: got %h want ACE1", u_p1.lfsr_q);
        end
        tick_edge();
        checks++;
        if (dat[0] !== 8'h70) begin
            errors++;
            $display("FAIL wrap_seamless: got %h want 70", dat[0]);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst_n  = 1'b0;
        model_reset();
        test_reset();
        test_period1_seq();
        test_period2_seq();
        test_reset_midrun();
        test_seed_zero();
        test_random();
        test_full_period();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
